// File: rtl/mul_add_pkg.sv
// Shared constants and result type for the multiply-add pipeline and its result collector.
package mul_add_pkg;

    localparam int unsigned MUL_ADD_LATENCY    = 3;
    localparam int unsigned MUL_ADD_WIDTH      = 32;
    localparam int unsigned MUL_ADD_FIFO_DEPTH = 5;

    typedef logic [MUL_ADD_WIDTH-1:0] mul_add_result_t;

endpackage

// File: rtl/mul_add_result_collector_if.sv
// Issue handshake, pipeline result, consumer handshake and credit view of the collector.
interface mul_add_result_collector_if
    import mul_add_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = MUL_ADD_WIDTH,
    parameter int unsigned DEPTH      = MUL_ADD_FIFO_DEPTH
);

    localparam int unsigned CREDIT_W = $clog2(DEPTH + 1);

    logic                  issue_valid;
    logic                  issue_ready;
    logic [DATA_WIDTH-1:0] pipe_result;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [CREDIT_W-1:0]   credits;

    // Issuer, pipeline and consumer side.
    modport master (
        output issue_valid,
        input  issue_ready,
        output pipe_result,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  credits
    );

    // Collector side.
    modport slave (
        input  issue_valid,
        output issue_ready,
        input  pipe_result,
        output out_valid,
        input  out_ready,
        output out_data,
        output credits
    );

endinterface

// File: rtl/mul_add_result_fifo.sv
// Synchronous FIFO of arbitrary (non power-of-two) depth; pointers wrap modulo DEPTH.
module mul_add_result_fifo #(
    parameter int unsigned DEPTH      = 5,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic                         rd_en,
    output logic [DATA_WIDTH-1:0]        rd_data,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  do_wr;
    logic                  do_rd;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A write at full is accepted only when a pop frees the head slot in the same cycle.
    always_comb begin
        do_rd    = rd_en && (count_q != '0);
        do_wr    = wr_en && ((count_q != CNT_W'(DEPTH)) || do_rd);
        wr_ptr_d = do_wr ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_rd ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + CNT_W'(do_wr) - CNT_W'(do_rd);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is cleared so the head reads zero out of reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign count   = count_q;

endmodule

// File: rtl/mul_add_result_collector.sv
// Sink of the fixed-latency multiply-add pipeline: tracks real issues, captures their
// results into a FIFO and hands out credits so the FIFO can never overflow.
module mul_add_result_collector
    import mul_add_pkg::*;
#(
    parameter int unsigned LATENCY    = MUL_ADD_LATENCY,
    parameter int unsigned DATA_WIDTH = MUL_ADD_WIDTH,
    parameter int unsigned DEPTH      = MUL_ADD_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    mul_add_result_collector_if.slave bus
);

    localparam int unsigned CREDIT_W = $clog2(DEPTH + 1);

    logic [CREDIT_W-1:0]   credits_q, credits_d;
    logic                  issue_ready_q, issue_ready_d;
    logic [LATENCY-1:0]    track_q, track_d;
    logic                  issue_fire;
    logic                  out_fire;
    logic                  fifo_wr;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [CREDIT_W-1:0]   fifo_count;
    logic [DATA_WIDTH-1:0] fifo_rd_data;

    // issue_ready is registered from the next credit value, so out_ready never reaches it combinationally.
    always_comb begin
        issue_fire    = bus.issue_valid && issue_ready_q;
        out_fire      = !fifo_empty && bus.out_ready;
        credits_d     = credits_q + CREDIT_W'(out_fire) - CREDIT_W'(issue_fire);
        issue_ready_d = (credits_d != '0);
        track_d       = (track_q << 1) | LATENCY'(issue_fire);
        fifo_wr       = track_q[LATENCY-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            credits_q     <= CREDIT_W'(DEPTH);
            issue_ready_q <= 1'b1;
            track_q       <= '0;
        end else begin
            credits_q     <= credits_d;
            issue_ready_q <= issue_ready_d;
            track_q       <= track_d;
        end
    end

    mul_add_result_fifo #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (fifo_wr),
        .wr_data (bus.pipe_result),
        .rd_en   (out_fire),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (fifo_count)
    );

    assign bus.issue_ready = issue_ready_q;
    assign bus.out_valid   = !fifo_empty;
    assign bus.out_data    = fifo_rd_data;
    assign bus.credits     = credits_q;

    // A write into a full FIFO means credit accounting is broken.
    a_no_write_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(fifo_wr && fifo_full));

    // Every credit is either free, in flight in the pipeline, or held by a stored result.
    a_credit_conservation: assert property (@(posedge clk) disable iff (!rst_n)
        (32'(fifo_count) + 32'($countones(track_q)) + 32'(credits_q)) == 32'(DEPTH));

endmodule

// File: tb/tb_mul_add_result_collector.sv
// Directed bench for mul_add_result_collector with a behavioural pipeline and a cycle model.
module tb_mul_add_result_collector;
    import mul_add_pkg::*;

    localparam int unsigned DEPTH = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mul_add_result_collector_if #(.DATA_WIDTH(MUL_ADD_WIDTH), .DEPTH(DEPTH)) bus ();

    mul_add_result_t x, y, z, p1, p2, p3;

    // Three-stage multiply-add pipeline with no reset and no flow control.
    always @(posedge clk) begin
        p1 <= x * y + z;
        p2 <= p1;
        p3 <= p2;
    end
    assign bus.pipe_result = p3;

    mul_add_result_collector #(
        .LATENCY    (MUL_ADD_LATENCY),
        .DATA_WIDTH (MUL_ADD_WIDTH),
        .DEPTH      (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Cycle model: credits, tracking bits, FIFO occupancy and expected result order.
    int              m_cred = 0;
    int              m_cnt  = 0;
    int              n_pop  = 0;
    logic [2:0]      m_track = '0;
    bit              model_ok = 1'b0;
    bit              hold_armed = 1'b0;
    mul_add_result_t hold_data;
    mul_add_result_t exp_q[$];

    always @(negedge clk) begin
        bit ifire;
        bit ofire;
        if (model_ok) begin
            check("credits", 32'(bus.credits), 32'(m_cred));
            check("issue_ready", 32'(bus.issue_ready), 32'(m_cred != 0));
            check("out_valid", 32'(bus.out_valid), 32'(m_cnt != 0));
            if (hold_armed && bus.out_valid) check("out_hold", bus.out_data, hold_data);
        end
        if (!rst_n) begin
            m_cred     = int'(DEPTH);
            m_cnt      = 0;
            m_track    = '0;
            hold_armed = 1'b0;
            exp_q.delete();
            model_ok   = 1'b1;
        end else if (model_ok) begin
            ifire = bus.issue_valid && (m_cred != 0);
            ofire = (m_cnt != 0) && bus.out_ready;
            if (ofire) begin
                check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check("out_data", bus.out_data, exp_q.pop_front());
                n_pop++;
            end
            if (ifire) exp_q.push_back(x * y + z);
            hold_armed = bus.out_valid && !bus.out_ready;
            hold_data  = bus.out_data;
            m_cnt      = m_cnt + int'(m_track[2]) - int'(ofire);
            m_track    = {m_track[1:0], ifire};
            m_cred     = m_cred + int'(ofire) - int'(ifire);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (exp_q.size() == 0 && m_cnt == 0 && m_track == 3'b000) break;
            step();
        end
        sample();
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int acc;
        int issued;

        rst_n = 1'b0;
        bus.issue_valid = 1'b0;
        bus.out_ready   = 1'b0;
        x = '0; y = '0; z = '0;
        repeat (3) step();
        sample();
        check("rst_credits", 32'(bus.credits), 32'd5);
        check("rst_issue_ready", 32'(bus.issue_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", bus.out_data, 32'd0);
        step();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (2) step();

        // Single issue 3*5+7 = 22.
        x = 3; y = 5; z = 7; bus.issue_valid = 1'b1;
        sample();
        check("single_cred_t0", 32'(bus.credits), 32'd5);
        step();
        bus.issue_valid = 1'b0;
        sample();
        check("single_cred_t1", 32'(bus.credits), 32'd4);
        check("single_valid_t1", 32'(bus.out_valid), 32'd0);
        step();
        step();
        sample();
        check("single_pipe_t3", bus.pipe_result, 32'd22);
        check("single_valid_t3", 32'(bus.out_valid), 32'd0);
        step();
        sample();
        check("single_valid_t4", 32'(bus.out_valid), 32'd1);
        check("single_data_t4", bus.out_data, 32'd22);
        check("single_cred_t4", 32'(bus.credits), 32'd4);
        step();
        sample();
        check("single_valid_t5", 32'(bus.out_valid), 32'd0);
        check("single_cred_t5", 32'(bus.credits), 32'd5);

        // Streaming: i*2+1 for 20 cycles with the consumer always ready.
        base = n_pop;
        for (int i = 0; i < 20; i++) begin
            step();
            x = i; y = 2; z = 1; bus.issue_valid = 1'b1;
            sample();
            check("stream_ready", 32'(bus.issue_ready), 32'd1);
        end
        step();
        bus.issue_valid = 1'b0;
        wait_drain(20);
        check("stream_count", 32'(n_pop - base), 32'd20);

        // Back-pressure: results 4k+3 = 3,7,11,15,19 fill the FIFO.
        base = n_pop;
        acc  = 0;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            x = k + 1; y = 3; z = k; bus.issue_valid = 1'b1;
            sample();
            if (bus.issue_ready) acc++;
        end
        check("bp_accepted", 32'(acc), 32'd5);
        check("bp_cred_zero", 32'(bus.credits), 32'd0);
        check("bp_ready_low", 32'(bus.issue_ready), 32'd0);
        repeat (4) step();
        sample();
        check("bp_full_valid", 32'(bus.out_valid), 32'd1);
        check("bp_full_head", bus.out_data, 32'd3);

        // Pop and issue together at the zero-credit boundary.
        step();
        bus.out_ready = 1'b1;
        x = 9; y = 9; z = 9;
        sample();
        check("bnd_cred_hold0", 32'(bus.credits), 32'd0);
        check("bnd_ready_low", 32'(bus.issue_ready), 32'd0);
        step();
        x = 10; y = 10; z = 0;
        sample();
        check("bnd_cred_one", 32'(bus.credits), 32'd1);
        check("bnd_ready_back", 32'(bus.issue_ready), 32'd1);
        step();
        x = 11; y = 1; z = 1;
        sample();
        check("bnd_cred_steady", 32'(bus.credits), 32'd1);
        step();
        bus.issue_valid = 1'b0;
        wait_drain(30);
        check("bp_count", 32'(n_pop - base), 32'd7);

        // Reset while three issues are in flight.
        step();
        x = 1; y = 1; z = 1; bus.issue_valid = 1'b1;
        step();
        x = 2;
        step();
        x = 3; rst_n = 1'b0;
        step();
        rst_n = 1'b1; bus.issue_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            sample();
            check("rst_flight_valid", 32'(bus.out_valid), 32'd0);
            check("rst_flight_cred", 32'(bus.credits), 32'd5);
            step();
        end
        x = 4; y = 4; z = 1; bus.issue_valid = 1'b1;
        step();
        bus.issue_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            sample();
            if (bus.out_valid) break;
            step();
        end
        check("post_rst_valid", 32'(bus.out_valid), 32'd1);
        check("post_rst_data", bus.out_data, 32'd17);
        wait_drain(10);

        // Wrap-around: 12 results 7i+100 through the 5-deep FIFO with random back-pressure.
        base   = n_pop;
        issued = 0;
        for (int c = 0; c < 300 && issued < 12; c++) begin
            step();
            x = issued; y = 7; z = 100; bus.issue_valid = 1'b1;
            bus.out_ready = 1'($urandom_range(0, 1));
            sample();
            if (bus.issue_ready) issued++;
        end
        check("wrap_issued", 32'(issued), 32'd12);
        step();
        bus.issue_valid = 1'b0;
        bus.out_ready   = 1'b1;
        wait_drain(40);
        check("wrap_count", 32'(n_pop - base), 32'd12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_add_result_collector.md
Name: mul_add_result_collector

Overview:
- Sink end of the fixed-latency, no-handshake multiply-add pipeline (out = x*y + z, 3 register stages, no flow control).
- Tracks which pipeline cycles carry real issues and captures those results into a small FIFO.
- Presents the captured results on a valid/ready output, and returns credits to the issuer so the pipeline never produces more results than the FIFO can hold.
- Sits between the pipeline output and any back-pressuring consumer.

Parameters:
- LATENCY, 3: cycles from an accepted issue (x/y/z presented to the pipeline) until its result is on pipe_result.
- DATA_WIDTH, 32: result width.
- DEPTH, 5: FIFO entries, also the credit pool size. Full throughput requires DEPTH >= LATENCY+2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- issue_valid  in  1  issuer wants to present x/y/z to the pipeline this cycle.
- issue_ready  out  1  a credit is available; the issue is accepted when issue_valid && issue_ready.
- pipe_result  in  DATA_WIDTH  pipeline output, sampled every cycle.
- out_valid  out  1  FIFO head holds a result.
- out_ready  in  1  consumer accepts the head.
- out_data  out  DATA_WIDTH  FIFO head.
- credits  out  $clog2(DEPTH+1)  current credit count (debug/perf).

Behaviour:
- Reset (rst_n=0 at an edge):
  - credits=DEPTH, issue_ready=1, out_valid=0, out_data=0.
  - Tracking shift register and FIFO pointers/count cleared.
  - The pipeline itself has no reset. Results already in flight at reset are discarded, because their tracking bits are cleared.
  - Reset mid-operation has the same effect; nothing issued before reset ever appears on out_*.
- Issue accept: issue_fire = issue_valid && issue_ready. issue_valid while issue_ready=0 is legal; it simply stalls, with no state change.
- issue_ready is credits != 0, decoded from a registered value only. It has no combinational path from out_ready.
- Credit update per edge:
  - credits += out_fire - issue_fire, where out_fire = out_valid && out_ready.
  - Simultaneous issue and pop leave credits unchanged.
  - credits is never below 0 or above DEPTH.
- In-flight tracking:
  - LATENCY-bit shift register. Bit 0 loads issue_fire; it shifts every cycle regardless of out_ready.
  - The tap is bit LATENCY-1. When the tap is set, pipe_result for that cycle is written to the FIFO at the edge.
  - pipe_result is ignored on all other cycles.
- Latency:
  - Issue accepted in cycle t, so its result is on pipe_result in cycle t+LATENCY.
  - That result is written at the end of cycle t+LATENCY, and out_valid=1 with out_data=result in cycle t+LATENCY+1.
- FIFO behaviour:
  - Results are delivered in issue order with no reordering.
  - out_data is driven from a register or RAM read with no combinational path from pipe_result.
  - out_data holds stable while out_valid=1 and out_ready=0.
- Full and empty:
  - Credits guarantee that a write never hits a full FIFO.
  - Write and pop in the same cycle are legal at any occupancy, including full and empty. Occupancy is unchanged.
  - On empty with a write, out_valid rises the next cycle (no same-cycle bypass).
- Wrap-around: read and write pointers wrap modulo DEPTH; DEPTH is not required to be a power of two.
- Assertion (simulation only): a FIFO write while full must never occur; it flags a credit accounting bug.

Decomposition:
- Package mul_add_pkg:
  - MUL_ADD_LATENCY=3 and MUL_ADD_WIDTH=32, shared with the pipeline wrapper.
  - Result type typedef logic [MUL_ADD_WIDTH-1:0] mul_add_result_t.
- One sub-module, mul_add_result_fifo:
  - Synchronous FIFO with DEPTH and DATA_WIDTH parameters.
  - Ports: wr_en/wr_data, rd_en/rd_data, empty/full/count, reset rst_n.
- The collector top holds the credit counter and the tracking shift register.

Test Plan:
- Single issue: x=3, y=5, z=7 issued in cycle 10 (bench pipeline model) -> pipe_result=22 in cycle 13; out_valid=1 with out_data=22 in cycle 14; credits 5→4 (cycle 11) → 5 (after pop).
- Streaming: out_ready=1, issue_valid=1 for 20 cycles with x=i, y=2, z=1 -> issue_ready never drops; outputs 1, 3, 5, … in order, one per cycle.
- Back-pressure: out_ready=0, issue_valid=1 -> exactly 5 issues accepted, then issue_ready=0 and credits=0. The FIFO fills to 5 with out_data constant. Raise out_ready -> 5 results in order, and issue_ready returns the cycle after the first pop.
- Simultaneous pop and issue at credits=0 boundary -> credits stays 0 that cycle, no loss or duplication, and the order is preserved.
- Reset mid-flight: issue 3 items, assert rst_n=0 one cycle before the first result reaches the tap -> after reset out_valid stays 0 for 10 cycles and credits=5. A subsequent issue of 4*4+1 yields 17.
- Non-power-of-two wrap: DEPTH=5, push/pop 12 items with random out_ready -> all 12 are delivered in order across pointer wrap.
